msg_to_point: RTL and testbench



---
 rtl/msg_to_point_pkg.sv | 29 ++
 rtl/msg_to_point_if.sv | 13 +
 rtl/msg_to_point_mod_mult.sv | 68 ++++++
 rtl/msg_to_point.sv | 155 +++++++++++++++
 tb/tb_msg_to_point.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_to_point_pkg.sv
// Shared constants and helpers for embedding plaintext integers onto secp256k1.
// State encodings are plain constants so older tools and netlists can read them directly.
package msg_to_point_pkg;

    localparam logic [255:0] SECP_P   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] CURVE_B  = 256'd7;
    localparam logic [255:0] SQRT_EXP = (SECP_P + 256'd1) >> 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_RANGE  = 3'd1;
    localparam state_t ST_FORM_X = 3'd2;
    localparam state_t ST_CUBE   = 3'd3;
    localparam state_t ST_SQRT   = 3'd4;
    localparam state_t ST_VERIFY = 3'd5;
    localparam state_t ST_DONE   = 3'd6;
    localparam state_t ST_FAIL   = 3'd7;

    // Both operands must already be reduced below p; one conditional subtract suffices.
    function automatic logic [255:0] add_mod(input logic [255:0] a, input logic [255:0] b,
                                             input logic [255:0] p);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, p}) s = s - {1'b0, p};
        return s[255:0];
    endfunction

endpackage

// File: rtl/msg_to_point_if.sv
// Request/result bundle between a message source and the point-embedding block.
interface msg_to_point_if;
    logic         Start;
    logic [255:0] message;
    logic [255:0] Mx;
    logic [255:0] My;
    logic         Done;
    logic         Fail;
    logic         Busy;

    modport master (output Start, message, input Mx, My, Done, Fail, Busy);
    modport slave  (input Start, message, output Mx, My, Done, Fail, Busy);
endinterface

// File: rtl/msg_to_point_mod_mult.sv
// Modular multiplier (a*b) mod P, MSB-first interleaved shift-add, DIGIT bits per cycle.
// Latency from req to ack is 256/DIGIT + 1 cycles; operands must be below P.
module msg_to_point_mod_mult
    import msg_to_point_pkg::*;
#(
    parameter logic [255:0] P     = SECP_P,
    parameter int           DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic         ack,
    output logic [255:0] res
);
    localparam int STEPS = 256 / DIGIT;

    logic         busy;
    logic [8:0]   cnt;
    logic [255:0] acc, a_q, b_q, nxt;

    function automatic logic [255:0] mm_step(input logic [255:0] acc_i, input logic [255:0] a_i,
                                             input logic bit_i);
        logic [256:0] t;
        t = {acc_i, 1'b0};
        if (t >= {1'b0, P}) t = t - {1'b0, P};
        if (bit_i) t = t + {1'b0, a_i};
        if (t >= {1'b0, P}) t = t - {1'b0, P};
        return t[255:0];
    endfunction

    always_comb begin
        nxt = acc;
        for (int i = 0; i < DIGIT; i++) nxt = mm_step(nxt, a_q, b_q[255 - i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            ack  <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (req && !busy) begin
                busy <= 1'b1;
                cnt  <= 9'(STEPS);
                acc  <= '0;
                a_q  <= a;
                b_q  <= b;
            end else if (busy) begin
                acc <= nxt;
                b_q <= b_q << DIGIT;
                cnt <= cnt - 9'd1;
                if (cnt == 9'd1) begin
                    busy <= 1'b0;
                    ack  <= 1'b1;
                end
            end
        end
    end

    assign res = acc;

endmodule

// File: rtl/msg_to_point.sv
// Koblitz embedding of a message onto y^2 = x^3 + B mod P: tries x = message*K + k, k = 0..K-1.
// state     | meaning            state     | meaning
// IDLE      | wait for Start     SQRT      | acc = rhs^((P+1)/4), 256 fixed bits
// RANGE     | message too large? VERIFY    | acc^2 == rhs? accept or next k
// FORM_X    | build x from k     DONE/FAIL | one-cycle pulse, drop Busy
// CUBE      | rhs = x^3 + B
module msg_to_point
    import msg_to_point_pkg::*;
#(
    parameter int           K     = 16,
    parameter logic [255:0] P     = SECP_P,
    parameter logic [255:0] B     = CURVE_B,
    parameter int           DIGIT = 1
) (
    input logic           Clk,
    input logic           Reset,
    msg_to_point_if.slave bus
);
    localparam int            LK     = $clog2(K);
    localparam int            KW     = (LK > 0) ? LK : 1;
    localparam logic [255:0]  E      = (P + 256'd1) >> 2;
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    state_t        state;
    logic [1:0]    ph;
    logic [KW-1:0] k;
    logic [8:0]    bit_idx;
    logic [255:0]  msg_q, x_q, rhs_q, acc_q, x_new;
    logic          mm_req, mm_ack;
    logic [255:0]  mm_a, mm_b, mm_res;

    assign x_new = (msg_q << LK) | 256'(k);

    msg_to_point_mod_mult #(.P(P), .DIGIT(DIGIT)) u_mult (
        .clk (Clk),
        .rst (Reset),
        .req (mm_req),
        .a   (mm_a),
        .b   (mm_b),
        .ack (mm_ack),
        .res (mm_res)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            ph       <= '0;
            k        <= '0;
            bit_idx  <= '0;
            msg_q    <= '0;
            x_q      <= '0;
            rhs_q    <= '0;
            acc_q    <= '0;
            mm_req   <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            bus.Mx   <= '0;
            bus.My   <= '0;
            bus.Done <= 1'b0;
            bus.Fail <= 1'b0;
            bus.Busy <= 1'b0;
        end else begin
            mm_req   <= 1'b0;
            bus.Done <= 1'b0;
            bus.Fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        msg_q    <= bus.message;
                        k        <= '0;
                        bus.Busy <= 1'b1;
                        state    <= ST_RANGE;
                    end
                end
                ST_RANGE: begin
                    if (msg_q >= (P >> LK)) begin
                        bus.Fail <= 1'b1;
                        state    <= ST_FAIL;
                    end else begin
                        state <= ST_FORM_X;
                    end
                end
                ST_FORM_X: begin
                    x_q    <= x_new;
                    mm_a   <= x_new;
                    mm_b   <= x_new;
                    mm_req <= 1'b1;
                    ph     <= 2'd0;
                    state  <= ST_CUBE;
                end
                ST_CUBE: begin
                    // ph: 0 = x*x, 1 = t*x, 2 = add B and launch the root chain from acc = 1
                    if (ph == 2'd2) begin
                        rhs_q   <= add_mod(rhs_q, B, P);
                        acc_q   <= 256'd1;
                        mm_a    <= 256'd1;
                        mm_b    <= 256'd1;
                        mm_req  <= 1'b1;
                        bit_idx <= 9'd255;
                        ph      <= 2'd0;
                        state   <= ST_SQRT;
                    end else if (mm_ack) begin
                        if (ph == 2'd0) begin
                            mm_a   <= mm_res;
                            mm_b   <= x_q;
                            mm_req <= 1'b1;
                            ph     <= 2'd1;
                        end else begin
                            rhs_q <= mm_res;
                            ph    <= 2'd2;
                        end
                    end
                end
                ST_SQRT: begin
                    if (mm_ack) begin
                        acc_q  <= mm_res;
                        mm_a   <= mm_res;
                        mm_req <= 1'b1;
                        if (ph == 2'd0 && E[bit_idx[7:0]]) begin
                            mm_b <= rhs_q;
                            ph   <= 2'd1;
                        end else begin
                            mm_b <= mm_res;
                            ph   <= 2'd0;
                            if (bit_idx == 9'd0) state <= ST_VERIFY;
                            else bit_idx <= bit_idx - 9'd1;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (mm_ack) begin
                        if (mm_res == rhs_q) begin
                            bus.Mx   <= x_q;
                            bus.My   <= acc_q;
                            bus.Done <= 1'b1;
                            state    <= ST_DONE;
                        end else if (k == K_LAST) begin
                            bus.Fail <= 1'b1;
                            state    <= ST_FAIL;
                        end else begin
                            k     <= k + KW'(1);
                            state <= ST_FORM_X;
                        end
                    end
                end
                ST_DONE, ST_FAIL: begin
                    bus.Busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_to_point.sv
// Directed bench for msg_to_point: K=16 and K=1 instances against a wide-arithmetic golden model.
module tb_msg_to_point;
    localparam logic [255:0] GP    = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] GE    = (GP + 256'd1) >> 2;
    localparam int           DIGIT = 128;
    localparam int           MC    = 256 / DIGIT + 2;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         start_r = 1'b0;
    logic         use1 = 1'b0;
    logic [255:0] msg_r = '0;
    int           nchk = 0;
    int           nfail = 0;
    int           pt, budget;

    msg_to_point_if b0 ();
    msg_to_point_if b1 ();

    assign b0.Start   = start_r & ~use1;
    assign b1.Start   = start_r & use1;
    assign b0.message = msg_r;
    assign b1.message = msg_r;

    logic         c_done, c_fail, c_busy;
    logic [255:0] c_mx, c_my;
    assign c_done = use1 ? b1.Done : b0.Done;
    assign c_fail = use1 ? b1.Fail : b0.Fail;
    assign c_busy = use1 ? b1.Busy : b0.Busy;
    assign c_mx   = use1 ? b1.Mx   : b0.Mx;
    assign c_my   = use1 ? b1.My   : b0.My;

    msg_to_point #(.K(16), .DIGIT(DIGIT)) dut0 (.Clk(Clk), .Reset(Reset), .bus(b0));
    msg_to_point #(.K(1),  .DIGIT(DIGIT)) dut1 (.Clk(Clk), .Reset(Reset), .bus(b1));

    always #5 Clk = ~Clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [255:0] mmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] pr;
        pr = {256'd0, a} * {256'd0, b};
        pr = pr % {256'd0, GP};
        return pr[255:0];
    endfunction

    function automatic logic [255:0] addm(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] s;
        s = ({256'd0, a} + {256'd0, b}) % {256'd0, GP};
        return s[255:0];
    endfunction

    function automatic logic [255:0] mpow(input logic [255:0] base, input logic [255:0] e);
        logic [255:0] r, s;
        r = 256'd1;
        s = base;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mmul(r, s);
            s = mmul(s, s);
        end
        return r;
    endfunction

    task automatic model(input logic [255:0] m, input int kk, output int tries, output logic ok,
                         output logic [255:0] x, output logic [255:0] y);
        logic [255:0] xx, rhs, yy;
        int lk;
        lk = $clog2(kk);
        ok = 1'b0;
        tries = 0;
        x = '0;
        y = '0;
        for (int k = 0; k < kk && !ok; k++) begin
            xx = (m << lk) | 256'(k);
            rhs = addm(mmul(mmul(xx, xx), xx), 256'd7);
            yy = mpow(rhs, GE);
            tries = k + 1;
            if (mmul(yy, yy) == rhs) begin
                ok = 1'b1;
                x = xx;
                y = yy;
            end
        end
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [255:0] m, input logic flood, output int cyc, output int nd,
                       output int nf, output logic busy_end);
        @(negedge Clk);
        start_r = 1'b1;
        msg_r = m;
        cyc = 0;
        nd = 0;
        nf = 0;
        busy_end = 1'b0;
        while (nd == 0 && nf == 0 && cyc < budget) begin
            @(negedge Clk);
            cyc++;
            if (c_done) nd++;
            if (c_fail) nf++;
            busy_end = c_busy;
            if (flood) begin
                start_r = c_busy;
                msg_r = m + 256'(cyc);
            end else begin
                start_r = 1'b0;
            end
        end
    endtask

    task automatic settle(input string tag);
        @(negedge Clk);
        start_r = 1'b0;
        check({tag, "_done_width"}, 256'(c_done), 256'd0);
        check({tag, "_busy_drop"}, 256'(c_busy), 256'd0);
    endtask

    initial begin
        int tries, cyc, nd, nf, extra;
        logic ok, bae, have_ok, have_bad;
        logic [255:0] ex, ey, sx, sy, m_ok, m_bad, ok_y, dx, dy;

        pt = (259 + $countones(GE)) * MC + 2;
        budget = 2 + 16 * pt + 20;

        repeat (3) @(negedge Clk);
        check("rst_mx", b0.Mx, 256'd0);
        check("rst_my", b0.My, 256'd0);
        check("rst_done", 256'(b0.Done), 256'd0);
        check("rst_fail", 256'(b0.Fail), 256'd0);
        check("rst_busy", 256'(b0.Busy), 256'd0);
        Reset = 1'b0;

        model(256'd68, 16, tries, ok, ex, ey);
        run(256'd68, 1'b0, cyc, nd, nf, bae);
        check("m68_latency", 256'(cyc), 256'(2 + tries * pt));
        check("m68_done", 256'(nd), 256'd1);
        check("m68_busy_at_done", 256'(bae), 256'd1);
        check("m68_mx", c_mx, ex);
        check("m68_my", c_my, ey);
        check("m68_mx_hi", c_mx >> 4, 256'd68);
        check("m68_mx_lt_p", 256'(c_mx < GP), 256'd1);
        check("m68_on_curve", mmul(c_my, c_my), addm(mmul(mmul(c_mx, c_mx), c_mx), 256'd7));
        settle("m68");
        sx = ex;
        sy = ey;

        run(GP >> 4, 1'b0, cyc, nd, nf, bae);
        check("range_latency", 256'(cyc), 256'd2);
        check("range_fail", 256'(nf), 256'd1);
        check("range_no_done", 256'(nd), 256'd0);
        check("range_mx_kept", c_mx, sx);
        check("range_my_kept", c_my, sy);
        settle("range");

        model(256'd3, 16, tries, ok, ex, ey);
        run(256'd3, 1'b1, cyc, nd, nf, bae);
        check("flood_latency", 256'(cyc), 256'(2 + tries * pt));
        check("flood_done", 256'(nd), 256'd1);
        check("flood_mx", c_mx, ex);
        check("flood_my", c_my, ey);
        settle("flood");
        extra = 0;
        repeat (20) begin
            @(negedge Clk);
            if (c_done || c_busy) extra++;
        end
        check("flood_no_extra", 256'(extra), 256'd0);

        @(negedge Clk);
        start_r = 1'b1;
        msg_r = 256'd9;
        @(negedge Clk);
        start_r = 1'b0;
        repeat (40) @(negedge Clk);
        check("pre_reset_busy", 256'(c_busy), 256'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("areset_mx", c_mx, 256'd0);
        check("areset_my", c_my, 256'd0);
        check("areset_busy", 256'(c_busy), 256'd0);
        check("areset_done", 256'(c_done), 256'd0);
        @(negedge Clk);
        Reset = 1'b0;

        model(256'd5, 16, tries, ok, ex, ey);
        run(256'd5, 1'b0, cyc, nd, nf, bae);
        check("m5_latency", 256'(cyc), 256'(2 + tries * pt));
        check("m5_mx", c_mx, ex);
        check("m5_my", c_my, ey);
        settle("m5");

        model(256'd0, 16, tries, ok, ex, ey);
        run(256'd0, 1'b0, cyc, nd, nf, bae);
        check("m0_done", 256'(nd), 256'd1);
        check("m0_mx_hi", c_mx >> 4, 256'd0);
        check("m0_mx", c_mx, ex);
        check("m0_my", c_my, ey);
        settle("m0");
        model(256'd1, 16, tries, ok, ex, ey);
        run(256'd1, 1'b0, cyc, nd, nf, bae);
        check("m1_latency", 256'(cyc), 256'(2 + tries * pt));
        check("m1_mx_hi", c_mx >> 4, 256'd1);
        check("m1_mx", c_mx, ex);
        check("m1_my", c_my, ey);
        settle("m1");

        use1 = 1'b1;
        have_ok = 1'b0;
        have_bad = 1'b0;
        m_ok = '0;
        m_bad = '0;
        ok_y = '0;
        for (int m = 2; m < 200 && !(have_ok && have_bad); m++) begin
            model(256'(m), 1, tries, ok, dx, dy);
            if (ok && !have_ok) begin
                have_ok = 1'b1;
                m_ok = 256'(m);
                ok_y = dy;
            end else if (!ok && !have_bad) begin
                have_bad = 1'b1;
                m_bad = 256'(m);
            end
        end
        run(m_ok, 1'b0, cyc, nd, nf, bae);
        check("k1_ok_latency", 256'(cyc), 256'(2 + pt));
        check("k1_ok_mx", c_mx, m_ok);
        check("k1_ok_my", c_my, ok_y);
        settle("k1_ok");
        run(m_bad, 1'b0, cyc, nd, nf, bae);
        check("k1_exhaust_latency", 256'(cyc), 256'(2 + pt));
        check("k1_exhaust_fail", 256'(nf), 256'd1);
        check("k1_exhaust_no_done", 256'(nd), 256'd0);
        check("k1_exhaust_mx_kept", c_mx, m_ok);
        check("k1_exhaust_my_kept", c_my, ok_y);
        settle("k1_exhaust");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
